// File: rtl/chunked_serial_adder_pkg.sv
// Shared types for the chunked serial adder.
package chunked_serial_adder_pkg;

    // Controller states: waiting for a request, or stepping through chunks.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/chunked_serial_adder_chunk_adder.sv
// CHUNK-bit ripple-carry adder built from full-adder cells; purely combinational.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    // One full-adder cell per bit; the carry ripples from bit 0 upwards.
    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[CHUNK];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// with a registered carry between chunks and a start/busy/done handshake.
module chunked_serial_adder
    import chunked_serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t state, state_next;

    // Operands and accumulator viewed as arrays of chunks so idx selects directly.
    logic [NCHUNK-1:0][CHUNK-1:0] a_reg, b_reg, acc_reg, acc_next;
    logic                         carry_reg;
    logic [IDX_W-1:0]             idx_reg;

    logic             load, step, last;
    logic [CHUNK-1:0] a_chunk, b_chunk, chunk_sum;
    logic             chunk_cout;

    // Next-state and control strobes; load on an accepted start, step every RUN
    // cycle, last on the final chunk.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx_reg == LAST_IDX) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    assign a_chunk = a_reg[idx_reg];
    assign b_chunk = b_reg[idx_reg];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_reg),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // Accumulator image with the current chunk result merged in; on the final
    // chunk this is the complete result, so sum_out never sees partial sums.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_acc
            assign acc_next[gi] = (idx_reg == IDX_W'(gi)) ? chunk_sum : acc_reg[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: latch operands on start, step one chunk per RUN cycle, publish on last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            sum_out   <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                // Subtraction is a + ~b + 1, so the carry-in is forced to 1.
                a_reg     <= a;
                b_reg     <= sub ? ~b : b;
                carry_reg <= sub ? 1'b1 : cin;
                idx_reg   <= '0;
            end
            if (step) begin
                acc_reg   <= acc_next;
                carry_reg <= chunk_cout;
                idx_reg   <= idx_reg + 1'b1;
            end
            if (last) begin
                sum_out <= acc_next;
                c_out   <= chunk_cout;
                ovf     <= (a_reg[NCHUNK-1][CHUNK-1] == b_reg[NCHUNK-1][CHUNK-1]) &&
                           (chunk_sum[CHUNK-1] != a_reg[NCHUNK-1][CHUNK-1]);
            end
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder (WIDTH=32, CHUNK=4) using a
// scoreboard queue filled at start and drained at done.
module tb_chunked_serial_adder;

    localparam int W      = 32;
    localparam int C      = 4;
    localparam int NCHUNK = W / C;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         c_out;
    logic         ovf;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    chunked_serial_adder #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .c_out   (c_out),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: a + b + cin, or a + ~b + 1 for subtraction.
    function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                   input logic vcin, input logic vsub);
        exp_t         e;
        logic [W-1:0] bx;
        logic [W:0]   full;
        bx   = vsub ? ~vb : vb;
        full = {1'b0, va} + {1'b0, bx} + {{W{1'b0}}, (vsub ? 1'b1 : vcin)};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.v  = (va[W-1] == bx[W-1]) && (full[W-1] != va[W-1]);
        return e;
    endfunction

    // Drive start for one cycle (called at a negedge), then scramble the inputs
    // so the DUT must rely on its latched copies. Returns at the next negedge.
    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vcin, input logic vsub, input bit push);
        start = 1'b1;
        a     = va;
        b     = vb;
        cin   = vcin;
        sub   = vsub;
        if (push) sb.push_back(model(va, vb, vcin, vsub));
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        cin   = 1'($urandom_range(1));
        sub   = 1'($urandom_range(1));
    endtask

    // Wait (bounded) for done; cycles counts negedges since the call.
    task automatic wait_done(output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 40) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cycles++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, sum_out, c_out, ovf} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_miss++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h c=%b v=%b, required all zero",
                     busy, done, sum_out, c_out, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_arith;
        logic [W-1:0] ta  [4] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005};
        logic [W-1:0] tb  [4] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0007};
        logic         tci [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic         tsb [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_t         e;
        int           cyc;
        bit           seen;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb[i], tci[i], tsb[i], 1'b1);
            n_vec++;
            if (busy !== 1'b1) begin
                n_miss++;
                $display("FAIL arith%0d_busy: busy=%b, required 1", i, busy);
            end
            wait_done(cyc, seen);
            e = sb.pop_front();
            n_vec++;
            if (!seen || cyc != NCHUNK) begin
                n_miss++;
                $display("FAIL arith%0d_latency: seen=%0d cycles=%0d, required %0d", i, seen, cyc, NCHUNK);
            end
            n_vec++;
            if ({sum_out, c_out, ovf} !== {e.s, e.c, e.v}) begin
                n_miss++;
                $display("FAIL arith%0d_result: sum=%h c=%b v=%b, required sum=%h c=%b v=%b",
                         i, sum_out, c_out, ovf, e.s, e.c, e.v);
            end
            $display("op a=%h b=%h cin=%0d sub=%0d -> sum=%h c=%0d v=%0d",
                     ta[i], tb[i], tci[i], tsb[i], sum_out, c_out, ovf);
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || sum_out !== e.s) begin
                n_miss++;
                $display("FAIL arith%0d_hold: done=%b sum=%h, required done=0 sum=%h", i, done, sum_out, e.s);
            end
        end
    endtask

    task automatic test_ignored_start;
        exp_t e;
        int   cyc;
        bit   seen;
        launch(32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        // Third cycle of the operation: a second request that must be ignored.
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
        cin   = 1'b0;
        sub   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, seen);
        e = sb.pop_front();
        n_vec++;
        if (!seen || cyc + 3 != NCHUNK) begin
            n_miss++;
            $display("FAIL ignored_latency: seen=%0d cycles=%0d, required %0d", seen, cyc + 3, NCHUNK);
        end
        n_vec++;
        if (sum_out !== e.s) begin
            n_miss++;
            $display("FAIL ignored_result: sum=%h, required %h", sum_out, e.s);
        end
        $display("op a=1 b=1 with ignored restart -> sum=%h", sum_out);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_miss++;
            $display("FAIL ignored_no_restart: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   cyc;
        bit   seen;
        launch(32'd10, 32'd20, 1'b0, 1'b0, 1'b1);
        wait_done(cyc, seen);
        e = sb.pop_front();
        n_vec++;
        if (!seen || sum_out !== e.s) begin
            n_miss++;
            $display("FAIL b2b_first: seen=%0d sum=%h, required %h", seen, sum_out, e.s);
        end
        $display("op a=10 b=20 -> sum=%h", sum_out);
        // Still in the done cycle: this start must be accepted.
        launch(32'd4, 32'd4, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (busy !== 1'b1) begin
            n_miss++;
            $display("FAIL b2b_accept: busy=%b, required 1", busy);
        end
        wait_done(cyc, seen);
        e = sb.pop_front();
        n_vec++;
        if (!seen || cyc != NCHUNK) begin
            n_miss++;
            $display("FAIL b2b_latency: seen=%0d cycles=%0d, required %0d", seen, cyc, NCHUNK);
        end
        n_vec++;
        if ({sum_out, c_out, ovf} !== {e.s, e.c, e.v}) begin
            n_miss++;
            $display("FAIL b2b_second: sum=%h c=%b v=%b, required sum=%h c=%b v=%b",
                     sum_out, c_out, ovf, e.s, e.c, e.v);
        end
        $display("op a=4 b=4 back-to-back -> sum=%h", sum_out);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        exp_t e;
        int   cyc;
        bit   seen;
        bit   stray;
        launch(32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, sum_out, c_out, ovf} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_miss++;
            $display("FAIL midreset_clear: busy=%b done=%b sum=%h c=%b v=%b, required all zero",
                     busy, done, sum_out, c_out, ovf);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        n_vec++;
        if (stray) begin
            n_miss++;
            $display("FAIL midreset_no_done: stray activity=1, required 0");
        end
        launch(32'd2, 32'd2, 1'b0, 1'b0, 1'b1);
        wait_done(cyc, seen);
        e = sb.pop_front();
        n_vec++;
        if (!seen || cyc != NCHUNK || sum_out !== e.s) begin
            n_miss++;
            $display("FAIL midreset_after: seen=%0d cycles=%0d sum=%h, required %0d cycles sum=%h",
                     seen, cyc, sum_out, NCHUNK, e.s);
        end
        $display("op a=2 b=2 after reset -> sum=%h", sum_out);
        @(negedge clk);
    endtask

    task automatic test_random;
        exp_t         e;
        int           cyc;
        bit           seen;
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1)); rs = 1'($urandom_range(1));
        launch(ra, rb, rc, rs, 1'b1);
        for (int i = 0; i < 24; i++) begin
            wait_done(cyc, seen);
            n_vec++;
            if (!seen || cyc != NCHUNK || sb.size() == 0) begin
                n_miss++;
                $display("FAIL rand%0d_timing: seen=%0d cycles=%0d, required %0d", i, seen, cyc, NCHUNK);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if ({sum_out, c_out, ovf} !== {e.s, e.c, e.v}) begin
                    n_miss++;
                    $display("FAIL rand%0d_result: sum=%h c=%b v=%b, required sum=%h c=%b v=%b",
                             i, sum_out, c_out, ovf, e.s, e.c, e.v);
                end
            end
            $display("rand %0d: a=%h b=%h cin=%0d sub=%0d -> sum=%h c=%0d v=%0d",
                     i, ra, rb, rc, rs, sum_out, c_out, ovf);
            if (i < 23) begin
                ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1)); rs = 1'($urandom_range(1));
                if (i % 4 == 0) begin ra[W-1] = rb[W-1]; end
                launch(ra, rb, rc, rs, 1'b1);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_arith;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid_op;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised, multi-cycle successor to the team's single-bit full adder.
- Adds, or optionally subtracts, two WIDTH-bit operands, CHUNK bits per clock, LSB chunk first, with a registered carry between chunks.
- Trades latency for area in the timing-analysis test designs; a start/busy/done handshake lets a controller sequence it.
- Also reports carry-out and signed overflow.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a positive multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only when busy=0.
- sub  input  1  0 = a+b+cin; 1 = a-b, computed as a+~b+1 with cin ignored.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in, used when sub=0.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result valid.
- sum_out  output  WIDTH  result.
- c_out  output  1  carry out of MSB. For sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Derived constant NCHUNK = WIDTH/CHUNK.
- Reset (rst_n=0, asynchronous): state IDLE; busy=0, done=0, sum_out=0, c_out=0, ovf=0; chunk index, carry register and operand latches all cleared. Reset asserted mid-operation abandons the operation, and no done is produced.
- States and transitions:
  - IDLE: busy=0. On start=1, go to RUN.
  - RUN: busy=1. When the chunk index equals NCHUNK-1, go to IDLE.
- On the start edge:
  - latch a into the operand A register.
  - latch b into the operand B register, or ~b when sub=1.
  - load the carry register with cin, or 1 when sub=1.
  - clear the chunk index and set busy=1.
- Each edge in RUN:
  - add chunk[idx] of the latched operands plus the carry register.
  - write the CHUNK result bits into the internal accumulator at position idx.
  - update the carry register and increment idx.
- Final chunk edge (idx=NCHUNK-1):
  - load sum_out from the full accumulator; load c_out from the final carry.
  - ovf = (A_msb == Bx_msb) && (result_msb != A_msb), where Bx is the latched (possibly inverted) B.
  - busy goes to 0 and done goes to 1 for exactly one cycle.
- Latency: done is high NCHUNK cycles after the start edge (8 for the defaults; 1 when CHUNK=WIDTH).
- Holding and visibility:
  - sum_out, c_out and ovf hold their value until the next completion.
  - Intermediate partial sums are never visible on sum_out.
- Start handling:
  - start while busy=1 is ignored; operands are not re-latched.
  - start in the cycle done=1 (busy already 0) is accepted, giving back-to-back operation with no bubble.
- Input stability: inputs a, b, cin and sub need only be stable on the start edge.
- Arithmetic: pure unsigned modulo 2^WIDTH. Carry-out and overflow appear only on c_out and ovf.

Decomposition:
- Shared package: state enum (IDLE, RUN).
- chunked_serial_adder computes the derived NCHUNK locally.
- One combinational sub-module, chunk_adder: a CHUNK-bit adder with cin/cout, built as a ripple of full-adder cells. It is instantiated once and fed by muxes selecting chunk[idx].

Test Plan (WIDTH=32, CHUNK=4):
- Basic add: a=0x00000005, b=0x00000003, cin=0, sub=0, start → busy for 8 cycles; done pulse; sum_out=0x00000008, c_out=0, ovf=0.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 → sum_out=0x00000000, c_out=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 → sum_out=0x80000000, c_out=0, ovf=1.
- Subtract with cin ignored: sub=1, a=5, b=7, cin=1 → sum_out=0xFFFFFFFE, c_out=0, ovf=0.
- Handshake:
  - start with a=1, b=1, then start again at cycle 3 with a=9, b=9 → ignored; result is 2.
  - start with a=4, b=4 in the done cycle → accepted; second done exactly 8 cycles later with sum_out=8.
- Reset mid-operation: pull rst_n low at cycle 4 of an operation → all outputs 0 immediately and no done. After release, a=2, b=2 completes with sum_out=4.
